instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set output FIFO entries (power of two, >=2).
REQ-002 Parameter MAX_LOOP_DEPTH, default 8, SHALL set the maximum legal loop nesting.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  instruction fields present.
REQ-006 in_ready  output  1  encoder accepts this cycle.
REQ-007 in_opcode  input  5  opcode 0..19 (MATMUL..JUMP_OR_END_LOOP).
REQ-008 in_operand  input  13  candidate payload for raw bits [5:17], ascending index.
REQ-009 out_valid  output  1  raw word available.
REQ-010 out_ready  input  1  consumer takes word.
REQ-011 out_instruction  output  [0:17]  raw instruction; opcode in [0:4].
REQ-012 loop_depth  output  $clog2(MAX_LOOP_DEPTH+1)  current open-loop count.
REQ-013 err_valid  output  1  one-cycle error pulse.
REQ-014 err_code  output  2  0 none, 1 illegal opcode, 2 loop overflow, 3 loop underflow.
REQ-015 err_sticky  output  1  set on any error, cleared only by reset.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal (fifo count < FIFO_DEPTH), with no combinational dependence on out_ready.
REQ-017 Encoded word SHALL be opcode in [0:4], operand bits masked per opcode, all other bits zero.
REQ-018 Mask: opcodes 0-6, 9-12 keep none; 7, 8 keep [5]; 13 keep [5:8]; 14 keep [5:6]; 15, 16 keep [5:15]; 17-19 keep [5:7]; bits [16:17] always zero.
REQ-019 Opcode >= 20 SHALL be accepted, not enqueued, and raise err_code 1.
REQ-020 Opcodes 17, 18 SHALL increment loop_depth; opcode 19 SHALL decrement it.
REQ-021 Opcode 17/18 at loop_depth == MAX_LOOP_DEPTH SHALL be dropped with err_code 2, depth unchanged.
REQ-022 Opcode 19 at loop_depth == 0 SHALL be dropped with err_code 3, depth unchanged.
REQ-023 err_valid/err_code SHALL be registered, asserted the cycle after the offending accept, then return to 0 unless another error is accepted.
REQ-024 Accepted legal word SHALL appear at FIFO tail; out_valid earliest one cycle after accept (latency 1, registered).
REQ-025 FIFO SHALL be strictly in-order; pop when out_valid && out_ready.
REQ-026 Simultaneous push and pop SHALL keep count unchanged, including when count == FIFO_DEPTH-1 and == 1.
REQ-027 out_instruction SHALL hold stable while out_valid && !out_ready.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH without loss.

Reset
REQ-029 On rst_n low, immediately: FIFO empty, out_valid 0, out_instruction 0, in_ready 0, loop_depth 0, err_valid 0, err_code 0, err_sticky 0.
REQ-030 in_ready SHALL rise the first cycle after rst_n deasserts; reset mid-transfer SHALL discard all queued words.

Configuration
REQ-031 Macro ENCODER_LOOP_CHECK_EN defined: REQ-020..022 active as specified.
REQ-032 Macro undefined: no depth counter, loop_depth tied 0, opcodes 17-19 always enqueued, err_code 2/3 never produced.

Structure
REQ-033 Shared package isa_pkg SHALL hold the e_opcode enum (values 0-19), INSTR_WIDTH = 18, OPCODE_WIDTH = 5, and the err_code enum.
REQ-034 FIFO SHALL be sub-module instr_fifo (parameterised width/depth, valid/ready both sides).

Verification
REQ-035 ADD (2), operand 13'h1FFF -> out_instruction 18'b00010_0000000000000, err_valid 0.
REQ-036 LOAD (15), operand all ones -> 18'b01111_11111111111_00; STORE (16) same operand -> opcode 10000, identical payload.
REQ-037 Five back-to-back accepts, out_ready 0, FIFO_DEPTH 4 -> in_ready low after 4th; release out_ready -> words out in order, none lost.
REQ-038 Opcode 21 -> no output word, err_valid one cycle with err_code 1, err_sticky 1.
REQ-039 With ENCODER_LOOP_CHECK_EN: nine START_LOOP (18) -> ninth dropped, err_code 2, loop_depth 8; JUMP_OR_END_LOOP (19) at depth 0 -> err_code 3.
REQ-040 rst_n low with 3 queued words -> out_valid 0 immediately, loop_depth 0, no stale word after release.

Source files
------------

// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the instruction encoder.
//   e_opcode      : 5-bit opcode enumeration, values 0..19
//   e_err_code    : 2-bit error code reported by the encoder
//   INSTR_WIDTH   : raw instruction width (opcode + payload)
//   OPCODE_WIDTH  : opcode field width
//   OPERAND_WIDTH : payload width (raw bits 5..17)
//   payload_mask  : per-opcode mask of payload bits kept in the raw word;
//                   mask bit 12 maps to raw bit 5, mask bit 0 to raw bit 17
// -----------------------------------------------------------------------------
package isa_pkg;

    localparam int INSTR_WIDTH   = 18;
    localparam int OPCODE_WIDTH  = 5;
    localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] MAX_OPCODE = 5'd19;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        MATMUL           = 5'd0,
        CONV             = 5'd1,
        ADD              = 5'd2,
        SUB              = 5'd3,
        MUL              = 5'd4,
        RELU             = 5'd5,
        POOL             = 5'd6,
        SHIFT            = 5'd7,
        SCALE            = 5'd8,
        NOP              = 5'd9,
        SYNC             = 5'd10,
        HALT             = 5'd11,
        FENCE            = 5'd12,
        CFG              = 5'd13,
        SEL              = 5'd14,
        LOAD             = 5'd15,
        STORE            = 5'd16,
        REPEAT           = 5'd17,
        START_LOOP       = 5'd18,
        JUMP_OR_END_LOOP = 5'd19
    } e_opcode;

    typedef enum logic [1:0] {
        ERR_NONE           = 2'd0,
        ERR_ILLEGAL_OPCODE = 2'd1,
        ERR_LOOP_OVERFLOW  = 2'd2,
        ERR_LOOP_UNDERFLOW = 2'd3
    } e_err_code;

    // Raw bits 16..17 are never part of any payload, so mask bits 1..0 are
    // always clear.
    function automatic logic [OPERAND_WIDTH-1:0] payload_mask(
        input logic [OPCODE_WIDTH-1:0] op
    );
        logic [OPERAND_WIDTH-1:0] m;
        m = '0;
        case (op)
            SHIFT, SCALE:                         m = 13'h1000; // [5]
            CFG:                                  m = 13'h1E00; // [5:8]
            SEL:                                  m = 13'h1800; // [5:6]
            LOAD, STORE:                          m = 13'h1FFC; // [5:15]
            REPEAT, START_LOOP, JUMP_OR_END_LOOP: m = 13'h1C00; // [5:7]
            default:                              m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Synchronous in-order FIFO with valid/ready on both sides. Output data is
// read straight from storage, so a word written on one edge is visible the
// following cycle. Output data reads as zero while empty.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   write handshake (in_ready = not full)
//   in_data             write data
//   out_valid/out_ready read handshake (out_valid = not empty)
//   out_data            head-of-queue data
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module instr_fifo #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Packs opcode + operand into an 18-bit raw instruction (opcode in bits 0..4,
// bit 0 is the MSB), masks the payload per opcode, tracks loop nesting and
// queues legal words in an output FIFO.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          instruction handshake
//   in_opcode, in_operand      instruction fields (operand bit 12 -> raw bit 5)
//   out_valid/out_ready        raw word handshake
//   out_instruction            raw word, ascending [0:17]
//   loop_depth                 current open-loop count
//   err_valid/err_code         registered one-cycle error report
//   err_sticky                 set on any error until reset
// Build option: define ENCODER_LOOP_CHECK_EN to enable the loop depth
// counter with overflow/underflow drop. Without it loop_depth reads 0 and
// loop opcodes are always queued.
// -----------------------------------------------------------------------------
module instruction_encoder
    import isa_pkg::*;
#(
    parameter  int FIFO_DEPTH     = 4,
    parameter  int MAX_LOOP_DEPTH = 8,
    localparam int LD_W           = $clog2(MAX_LOOP_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_WIDTH-1:0]  in_opcode,
    input  logic [OPERAND_WIDTH-1:0] in_operand,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:INSTR_WIDTH-1]   out_instruction,
    output logic [LD_W-1:0]          loop_depth,
    output logic                     err_valid,
    output logic [1:0]               err_code,
    output logic                     err_sticky
);

    logic                   r_run;
    logic                   r_err_valid;
    e_err_code              r_err_code;
    logic                   r_err_sticky;
    logic                   w_fifo_ready;
    logic                   w_accept;
    logic                   w_illegal;
    logic                   w_loop_ovf;
    logic                   w_loop_unf;
    logic                   w_push;
    e_err_code              w_err_next;
    logic [INSTR_WIDTH-1:0] w_word;
    logic [INSTR_WIDTH-1:0] w_fifo_data;

    // r_run holds in_ready low through reset and for the release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    assign in_ready  = r_run && w_fifo_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_illegal = (in_opcode > MAX_OPCODE);
    assign w_word    = {in_opcode, in_operand & payload_mask(in_opcode)};

`ifdef ENCODER_LOOP_CHECK_EN
    logic [LD_W-1:0] r_loop_depth;
    logic            w_is_open;
    logic            w_is_close;

    assign w_is_open  = (in_opcode == REPEAT) || (in_opcode == START_LOOP);
    assign w_is_close = (in_opcode == JUMP_OR_END_LOOP);
    assign w_loop_ovf = w_accept && w_is_open  && (r_loop_depth == LD_W'(MAX_LOOP_DEPTH));
    assign w_loop_unf = w_accept && w_is_close && (r_loop_depth == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loop_depth <= '0;
        end else if (w_accept && w_is_open && !w_loop_ovf) begin
            r_loop_depth <= r_loop_depth + 1'b1;
        end else if (w_accept && w_is_close && !w_loop_unf) begin
            r_loop_depth <= r_loop_depth - 1'b1;
        end
    end

    assign loop_depth = r_loop_depth;
`else
    assign w_loop_ovf = 1'b0;
    assign w_loop_unf = 1'b0;
    assign loop_depth = '0;
`endif

    assign w_push = w_accept && !w_illegal && !w_loop_ovf && !w_loop_unf;

    always_comb begin
        w_err_next = ERR_NONE;
        if (w_accept) begin
            if (w_illegal)       w_err_next = ERR_ILLEGAL_OPCODE;
            else if (w_loop_ovf) w_err_next = ERR_LOOP_OVERFLOW;
            else if (w_loop_unf) w_err_next = ERR_LOOP_UNDERFLOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_sticky <= 1'b0;
        end else begin
            r_err_valid <= (w_err_next != ERR_NONE);
            r_err_code  <= w_err_next;
            if (w_err_next != ERR_NONE) r_err_sticky <= 1'b1;
        end
    end

    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign err_sticky = r_err_sticky;

    instr_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_push),
        .in_ready  (w_fifo_ready),
        .in_data   (w_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_fifo_data)
    );

    // Descending fifo data lands MSB-first on the ascending port: bit 0 = MSB.
    assign out_instruction = w_fifo_data;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    localparam int DEPTH = 4;
    localparam int MAXLD = 8;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        in_valid   = 1'b0;
    logic        out_ready  = 1'b0;
    logic [4:0]  in_opcode  = '0;
    logic [12:0] in_operand = '0;
    logic        in_ready;
    logic        out_valid;
    logic [0:17] out_instruction;
    logic [3:0]  loop_depth;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        err_sticky;

    int          n_checks = 0;
    int          n_pass   = 0;

    // reference model state
    logic [17:0] exp_q[$];
    int          occ      = 0;
    int          mdepth   = 0;
    bit          running  = 1'b0;
    bit          sticky   = 1'b0;
    logic [1:0]  pend_err = 2'd0;

    always #5 clk = ~clk;

    instruction_encoder #(
        .FIFO_DEPTH     (DEPTH),
        .MAX_LOOP_DEPTH (MAXLD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_operand      (in_operand),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .loop_depth      (loop_depth),
        .err_valid       (err_valid),
        .err_code        (err_code),
        .err_sticky      (err_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Payload kept is raw bits 5..hi; a word is opcode followed by that many
    // leading operand bits.
    function automatic logic [17:0] exp_word(input int op, input logic [12:0] opd);
        int          hi;
        int          n;
        logic [12:0] mask;
        if (op == 7 || op == 8)          hi = 5;
        else if (op == 13)               hi = 8;
        else if (op == 14)               hi = 6;
        else if (op == 15 || op == 16)   hi = 15;
        else if (op >= 17 && op <= 19)   hi = 7;
        else                             hi = 4;
        n    = hi - 4;
        mask = 13'(((1 << n) - 1) << (13 - n));
        return {5'(op), opd & mask};
    endfunction

    // One clock: drive after the rising edge, check and advance the model at
    // the falling edge (the accept it predicts happens on the next rising edge).
    task automatic cycle(input bit v, input logic [4:0] op, input logic [12:0] opd, input bit ordy);
        bit         acc;
        bit         push;
        logic [1:0] e;
        @(posedge clk);
        #1;
        in_valid   = v;
        in_opcode  = op;
        in_operand = opd;
        out_ready  = ordy;
        @(negedge clk);
        chk("in_ready",   32'(in_ready),   32'(running && occ < DEPTH));
        chk("out_valid",  32'(out_valid),  32'(occ > 0));
        chk("err_valid",  32'(err_valid),  32'(pend_err != 2'd0));
        chk("err_code",   32'(err_code),   32'(pend_err));
        chk("err_sticky", 32'(err_sticky), 32'(sticky));
        chk("loop_depth", 32'(loop_depth), 32'(mdepth));
        acc  = v && running && (occ < DEPTH);
        push = 1'b0;
        e    = 2'd0;
        if (acc) begin
            if (op > 5'd19) e = 2'd1;
`ifdef ENCODER_LOOP_CHECK_EN
            else if ((op == 5'd17 || op == 5'd18) && mdepth == MAXLD) e = 2'd2;
            else if (op == 5'd19 && mdepth == 0) e = 2'd3;
            else begin
                push = 1'b1;
                if (op == 5'd17 || op == 5'd18) mdepth++;
                else if (op == 5'd19) mdepth--;
            end
`else
            else push = 1'b1;
`endif
        end
        if (e != 2'd0) sticky = 1'b1;
        pend_err = e;
        if (occ > 0 && ordy) occ--;
        if (push) begin
            exp_q.push_back(exp_word(int'(op), opd));
            occ++;
        end
    endtask

    task automatic do_reset();
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid",  32'(out_valid),       32'd0);
        chk("rst_out_instr",  32'(out_instruction), 32'd0);
        chk("rst_in_ready",   32'(in_ready),        32'd0);
        chk("rst_loop_depth", 32'(loop_depth),      32'd0);
        chk("rst_err_valid",  32'(err_valid),       32'd0);
        chk("rst_err_code",   32'(err_code),        32'd0);
        chk("rst_err_sticky", 32'(err_sticky),      32'd0);
        exp_q.delete();
        occ      = 0;
        mdepth   = 0;
        sticky   = 1'b0;
        pend_err = 2'd0;
        running  = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd0);
        running = 1'b1;
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_word: got %h with no word expected at %0t", out_instruction, $time);
                end else begin
                    chk("out_word", 32'(out_instruction), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // field packing
        cycle(1'b1, 5'd2,  13'h1FFF, 1'b1);
        cycle(1'b1, 5'd15, 13'h1FFF, 1'b1);
        cycle(1'b1, 5'd16, 13'h1FFF, 1'b1);
        cycle(1'b1, 5'd13, 13'h1ABC, 1'b1);
        cycle(1'b1, 5'd14, 13'h1FFF, 1'b1);
        cycle(1'b1, 5'd7,  13'h1555, 1'b1);
        cycle(1'b0, 5'd0,  13'h0,    1'b1);
        cycle(1'b0, 5'd0,  13'h0,    1'b1);

        // fill with the consumer stalled, then drain
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'(13 + i), 13'($urandom), 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 5'd0, 13'h0, 1'b1);

        // illegal opcode
        cycle(1'b1, 5'd21, 13'h1FFF, 1'b1);
        cycle(1'b0, 5'd0,  13'h0,    1'b1);
        cycle(1'b0, 5'd0,  13'h0,    1'b1);

        // loop nesting: overflow then underflow
        for (int i = 0; i < 9; i++) cycle(1'b1, 5'd18, 13'($urandom), 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 5'd19, 13'($urandom), 1'b1);
        cycle(1'b0, 5'd0, 13'h0, 1'b1);
        cycle(1'b0, 5'd0, 13'h0, 1'b1);

        // reset with queued words
        cycle(1'b1, 5'd18, 13'h1FFF, 1'b0);
        cycle(1'b1, 5'd15, 13'h0F0F, 1'b0);
        cycle(1'b1, 5'd16, 13'h1234, 1'b0);
        cycle(1'b0, 5'd0,  13'h0,    1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 13'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            op = ($urandom_range(0, 9) < 2) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
            cycle($urandom_range(0, 9) < 7, 5'(op), 13'($urandom), $urandom_range(0, 9) < 6);
        end

        for (int i = 0; i < 12; i++) cycle(1'b0, 5'd0, 13'h0, 1'b1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
